// File: rtl/lc_token_trans_check.sv
// Life-cycle transition token checker: looks up the token index for a (cur,tgt) edge,
// then compares the caller token against the selected hashed constant twice, chunk by chunk.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for req_i; accept captures cur/tgt/token
// LOOKUP  | range check and matrix lookup of the token index
// CHECK0  | first constant-time pass over all chunks into mis0
// CHECK1  | second pass into mis1, then compare both passes
// DONE    | one-cycle done_o pulse, then back to IDLE
// ERROR   | terminal fault state, left only through rst_i
module lc_token_trans_check #(
  parameter  int unsigned NumStates  = 21,
  parameter  int unsigned NumTokens  = 8,
  parameter  int unsigned TokenWidth = 128,
  parameter  int unsigned ChunkWidth = 32,
  parameter  int unsigned InvalidIdx = NumTokens - 1,
  parameter  int unsigned StW        = $clog2(NumStates),
  localparam int unsigned IdxW       = $clog2(NumTokens),
  localparam int unsigned NumChunks  = TokenWidth / ChunkWidth,
  localparam int unsigned CntW       = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumStates*NumStates*IdxW-1:0] trans_matrix_i,
  input  logic [NumTokens*TokenWidth-1:0]     hashed_tokens_i,
  input  logic                                req_i,
  input  logic [StW-1:0]                      cur_state_i,
  input  logic [StW-1:0]                      tgt_state_i,
  input  logic [TokenWidth-1:0]               token_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [3:0]                          result_o,
  output logic [1:0]                          err_code_o,
  output logic                                fsm_err_o
);

  localparam logic [3:0]      LcTxOn  = 4'b0101;
  localparam logic [3:0]      LcTxOff = 4'b1010;
  localparam logic [IdxW-1:0] InvIdx  = IdxW'(InvalidIdx);
  localparam logic [StW-1:0]  MaxSt   = StW'(NumStates - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  // Encodings keep a pairwise Hamming distance of at least 3.
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000000,
    ST_LOOKUP = 6'b000111,
    ST_CHECK0 = 6'b011001,
    ST_CHECK1 = 6'b101010,
    ST_DONE   = 6'b110100,
    ST_ERROR  = 6'b111111
  } state_e;

  logic [5:0]            state_q, state_d;
  logic [StW-1:0]        cur_q, cur_d, tgt_q, tgt_d;
  logic [TokenWidth-1:0] token_q, token_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  mis0_q, mis0_d, mis1_q, mis1_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [3:0]            result_q, result_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  fsm_err_q, fsm_err_d;

  logic [IdxW-1:0]       mat_entry [NumStates][NumStates];
  logic [ChunkWidth-1:0] ref_chunk [NumTokens][NumChunks];
  logic [ChunkWidth-1:0] cap_chunk [NumChunks];

  for (genvar i = 0; i < NumStates; i++) begin : g_mat_row
    for (genvar j = 0; j < NumStates; j++) begin : g_mat_col
      assign mat_entry[i][j] = trans_matrix_i[(i*NumStates+j)*IdxW +: IdxW];
    end
  end

  for (genvar k = 0; k < NumTokens; k++) begin : g_tok
    for (genvar c = 0; c < NumChunks; c++) begin : g_tok_chunk
      assign ref_chunk[k][c] = hashed_tokens_i[k*TokenWidth + c*ChunkWidth +: ChunkWidth];
    end
  end

  for (genvar c = 0; c < NumChunks; c++) begin : g_cap_chunk
    assign cap_chunk[c] = token_q[c*ChunkWidth +: ChunkWidth];
  end

  logic            chunk_mis;
  logic            mis1_fin;
  logic            bad_edge;
  logic            enter_err;
  logic [IdxW-1:0] entry;

  always_comb begin
    entry     = mat_entry[cur_q][tgt_q];
    bad_edge  = (cur_q > MaxSt) || (tgt_q > MaxSt) || (entry == InvIdx);
    chunk_mis = (cap_chunk[cnt_q] != ref_chunk[idx_q][cnt_q]);
    mis1_fin  = mis1_q | chunk_mis;
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    token_d    = token_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mis0_d     = mis0_q;
    mis1_d     = mis1_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    err_code_d = err_code_q;
    fsm_err_d  = fsm_err_q;
    enter_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cur_d      = cur_state_i;
          tgt_d      = tgt_state_i;
          token_d    = token_i;
          cnt_d      = '0;
          mis0_d     = 1'b0;
          mis1_d     = 1'b0;
          result_d   = LcTxOff;
          err_code_d = 2'd0;
          busy_d     = 1'b1;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cnt_d = '0;
        if (bad_edge) begin
          err_code_d = 2'd1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          idx_d   = entry;
          state_d = ST_CHECK0;
        end
      end
      ST_CHECK0: begin
        // Every chunk is compared even after a mismatch so latency is data-independent.
        mis0_d = mis0_q | chunk_mis;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = ST_CHECK1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK1: begin
        mis1_d = mis1_fin;
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (mis0_q != mis1_fin) begin
            enter_err = 1'b1;
          end else if (!mis0_q) begin
            result_d   = LcTxOn;
            err_code_d = 2'd0;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            err_code_d = 2'd2;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERROR: enter_err = 1'b1;
      default:  enter_err = 1'b1;
    endcase

    // A result register outside {On, Off} can only come from a fault.
    if (result_q != LcTxOn && result_q != LcTxOff) begin
      enter_err = 1'b1;
    end

    if (enter_err) begin
      state_d    = ST_ERROR;
      fsm_err_d  = 1'b1;
      result_d   = LcTxOff;
      err_code_d = 2'd3;
      busy_d     = 1'b1;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      tgt_q      <= '0;
      token_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      mis0_q     <= 1'b0;
      mis1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= LcTxOff;
      err_code_q <= 2'd0;
      fsm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      token_q    <= token_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mis0_q     <= mis0_d;
      mis1_q     <= mis1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      fsm_err_q  <= fsm_err_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign err_code_o = err_code_q;
  assign fsm_err_o  = fsm_err_q;

endmodule

// File: tb/tb_lc_token_trans_check.sv
// Bench for lc_token_trans_check: default-parameter instance plus a small 8-state/4-token
// instance, checked against a transaction-level model of the edge/token rules.
module tb_lc_token_trans_check;

  localparam logic [3:0] ON  = 4'b0101;
  localparam logic [3:0] OFF = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default instance: 21 states, 8 tokens, 128-bit tokens, 32-bit chunks.
  logic                rst1;
  logic [21*21*3-1:0]  tm1;
  logic [8*128-1:0]    ht1;
  logic                req1;
  logic [4:0]          cur1, tgt1;
  logic [127:0]        tok_in1;
  logic                busy1, done1, ferr1;
  logic [3:0]          res1;
  logic [1:0]          code1;
  logic [2:0]          mat1 [21][21];
  logic [127:0]        tok1 [8];

  lc_token_trans_check dut1 (
    .clk_i(clk), .rst_i(rst1), .trans_matrix_i(tm1), .hashed_tokens_i(ht1),
    .req_i(req1), .cur_state_i(cur1), .tgt_state_i(tgt1), .token_i(tok_in1),
    .busy_o(busy1), .done_o(done1), .result_o(res1), .err_code_o(code1), .fsm_err_o(ferr1)
  );

  // Small instance: 8 states, 4 tokens, 64-bit tokens, 16-bit chunks.
  logic                rst2;
  logic [8*8*2-1:0]    tm2;
  logic [4*64-1:0]     ht2;
  logic                req2;
  logic [2:0]          cur2, tgt2;
  logic [63:0]         tok_in2;
  logic                busy2, done2, ferr2;
  logic [3:0]          res2;
  logic [1:0]          code2;
  logic [1:0]          mat2 [8][8];
  logic [63:0]         tok2 [4];

  lc_token_trans_check #(
    .NumStates(8), .NumTokens(4), .TokenWidth(64), .ChunkWidth(16)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2), .trans_matrix_i(tm2), .hashed_tokens_i(ht2),
    .req_i(req2), .cur_state_i(cur2), .tgt_state_i(tgt2), .token_i(tok_in2),
    .busy_o(busy2), .done_o(done2), .result_o(res2), .err_code_o(code2), .fsm_err_o(ferr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Edge rules: out-of-range or forbidden edge -> code 1 after 2 cycles;
  // otherwise full double pass -> 10 cycles, pass iff token equals the selected constant.
  function automatic void model1(input int cur, input int tgt, input logic [127:0] tok,
                                 output int lat, output logic [3:0] res, output logic [1:0] code);
    lat = 2; res = OFF; code = 2'd1;
    if (cur < 21 && tgt < 21) begin
      if (mat1[cur][tgt] != 3'd7) begin
        lat  = 10;
        res  = (tok == tok1[mat1[cur][tgt]]) ? ON : OFF;
        code = (tok == tok1[mat1[cur][tgt]]) ? 2'd0 : 2'd2;
      end
    end
  endfunction

  function automatic void model2(input int cur, input int tgt, input logic [63:0] tok,
                                 output int lat, output logic [3:0] res, output logic [1:0] code);
    lat = 2; res = OFF; code = 2'd1;
    if (mat2[cur][tgt] != 2'd3) begin
      lat  = 10;
      res  = (tok == tok2[mat2[cur][tgt]]) ? ON : OFF;
      code = (tok == tok2[mat2[cur][tgt]]) ? 2'd0 : 2'd2;
    end
  endfunction

  // Issues one request from an idle cycle (cycle 0) and reports the cycle done_o rose (-1 on timeout).
  task automatic run1(input int cur, input int tgt, input logic [127:0] tok,
                      output int lat, output logic [3:0] res, output logic [1:0] code, output logic bsy);
    cur1 = 5'(cur); tgt1 = 5'(tgt); tok_in1 = tok; req1 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      req1 = 1'b0;
      if (done1 === 1'b1) begin lat = c; break; end
    end
    res = res1; code = code1; bsy = busy1;
    tick();
  endtask

  task automatic run2(input int cur, input int tgt, input logic [63:0] tok,
                      output int lat, output logic [3:0] res, output logic [1:0] code);
    cur2 = 3'(cur); tgt2 = 3'(tgt); tok_in2 = tok; req2 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      req2 = 1'b0;
      if (done2 === 1'b1) begin lat = c; break; end
    end
    res = res2; code = code2;
    tick();
  endtask

  task automatic test_reset();
    n_checks += 5;
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    if (done1 !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done1); end
    if (res1 !== OFF) begin n_errors++; $display("FAIL reset_result: got %b want %b", res1, OFF); end
    if (code1 !== 2'd0) begin n_errors++; $display("FAIL reset_code: got %0d want 0", code1); end
    if (ferr1 !== 1'b0) begin n_errors++; $display("FAIL reset_fsm_err: got %b want 0", ferr1); end
  endtask

  task automatic test_pass_and_mismatch();
    int lat; logic [3:0] res; logic [1:0] code; logic bsy;
    logic [127:0] t;
    run1(0, 1, tok1[1], lat, res, code, bsy);
    n_checks += 4;
    if (lat != 10) begin n_errors++; $display("FAIL pass_latency: got %0d want 10", lat); end
    if (res !== ON) begin n_errors++; $display("FAIL pass_result: got %b want %b", res, ON); end
    if (code !== 2'd0) begin n_errors++; $display("FAIL pass_code: got %0d want 0", code); end
    if (bsy !== 1'b1) begin n_errors++; $display("FAIL pass_busy_at_done: got %b want 1", bsy); end
    n_checks += 2;
    if (res1 !== ON) begin n_errors++; $display("FAIL pass_result_hold: got %b want %b", res1, ON); end
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL pass_busy_after: got %b want 0", busy1); end
    t = tok1[1];
    t[127] = ~t[127];
    run1(0, 1, t, lat, res, code, bsy);
    n_checks += 3;
    if (lat != 10) begin n_errors++; $display("FAIL mismatch_latency: got %0d want 10", lat); end
    if (res !== OFF) begin n_errors++; $display("FAIL mismatch_result: got %b want %b", res, OFF); end
    if (code !== 2'd2) begin n_errors++; $display("FAIL mismatch_code: got %0d want 2", code); end
  endtask

  task automatic test_invalid_edge();
    int lat; logic [3:0] res; logic [1:0] code; logic bsy;
    int cs [3] = '{20, 25, 3};
    int ts [3] = '{0, 1, 30};
    for (int i = 0; i < 3; i++) begin
      run1(cs[i], ts[i], tok1[0], lat, res, code, bsy);
      n_checks += 3;
      if (lat != 2) begin n_errors++; $display("FAIL invalid_latency[%0d]: got %0d want 2", i, lat); end
      if (res !== OFF) begin n_errors++; $display("FAIL invalid_result[%0d]: got %b want %b", i, res, OFF); end
      if (code !== 2'd1) begin n_errors++; $display("FAIL invalid_code[%0d]: got %0d want 1", i, code); end
    end
  endtask

  task automatic test_random();
    int lat, elat; logic [3:0] res, eres; logic [1:0] code, ecode; logic bsy;
    int cur, tgt, k, sel;
    logic [127:0] t;
    for (int n = 0; n < 40; n++) begin
      cur = $urandom_range(0, 23);
      tgt = $urandom_range(0, 23);
      k   = (cur < 21 && tgt < 21) ? int'(mat1[cur][tgt]) : $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      t   = tok1[k];
      if (sel == 1) t[$urandom_range(0, 127)] ^= 1'b1;
      if (sel == 2) t = rand128();
      model1(cur, tgt, t, elat, eres, ecode);
      run1(cur, tgt, t, lat, res, code, bsy);
      n_checks++;
      if (lat != elat || res !== eres || code !== ecode) begin
        n_errors++;
        $display("FAIL random[%0d] cur=%0d tgt=%0d: got lat=%0d res=%b code=%0d want lat=%0d res=%b code=%0d",
                 n, cur, tgt, lat, res, code, elat, eres, ecode);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad_done = 0;
    cur1 = 5'd0; tgt1 = 5'd1; tok_in1 = tok1[1]; req1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req1 = 1'b0;
      if (done1 !== (c == 10)) bad_done++;
      if (c == 3 || c == 10) begin
        cur1 = 5'd20; tgt1 = 5'd0; req1 = 1'b1;
      end
    end
    n_checks += 3;
    if (bad_done != 0) begin n_errors++; $display("FAIL b2b_done_timing: got %0d bad cycles want 0", bad_done); end
    if (res1 !== ON) begin n_errors++; $display("FAIL b2b_result: got %b want %b", res1, ON); end
    if (code1 !== 2'd0) begin n_errors++; $display("FAIL b2b_code: got %0d want 0", code1); end
    tick();
    req1 = 1'b1;
    n_checks += 2;
    if (done1 !== 1'b0) begin n_errors++; $display("FAIL b2b_c11_done: got %b want 0", done1); end
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL b2b_c11_busy: got %b want 0", busy1); end
    tick();
    req1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL b2b_c12_busy: got %b want 1", busy1); end
    tick();
    n_checks += 2;
    if (done1 !== 1'b1) begin n_errors++; $display("FAIL b2b_c13_done: got %b want 1", done1); end
    if (code1 !== 2'd1) begin n_errors++; $display("FAIL b2b_c13_code: got %0d want 1", code1); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic [3:0] res; logic [1:0] code; logic bsy;
    int spurious = 0;
    cur1 = 5'd0; tgt1 = 5'd1; tok_in1 = tok1[1]; req1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      req1 = 1'b0;
    end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    n_checks += 4;
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
    if (res1 !== OFF) begin n_errors++; $display("FAIL rstmid_result: got %b want %b", res1, OFF); end
    if (code1 !== 2'd0) begin n_errors++; $display("FAIL rstmid_code: got %0d want 0", code1); end
    if (done1 !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b want 0", done1); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done1 !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", spurious); end
    run1(0, 1, tok1[1], lat, res, code, bsy);
    n_checks++;
    if (lat != 10 || res !== ON || code !== 2'd0) begin
      n_errors++;
      $display("FAIL rstmid_next: got lat=%0d res=%b code=%0d want lat=10 res=%b code=0", lat, res, code, ON);
    end
  endtask

  task automatic test_fault_mis1();
    int bad_done = 0;
    cur1 = 5'd0; tgt1 = 5'd1; tok_in1 = tok1[1]; req1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req1 = 1'b0;
      if (c == 6) force dut1.mis1_q = 1'b1;
      if (done1 !== 1'b0) bad_done++;
    end
    release dut1.mis1_q;
    n_checks += 4;
    if (ferr1 !== 1'b1) begin n_errors++; $display("FAIL mis1_fsm_err: got %b want 1", ferr1); end
    if (code1 !== 2'd3) begin n_errors++; $display("FAIL mis1_code: got %0d want 3", code1); end
    if (res1 !== OFF) begin n_errors++; $display("FAIL mis1_result: got %b want %b", res1, OFF); end
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL mis1_busy: got %b want 1", busy1); end
    for (int c = 0; c < 6; c++) begin
      req1 = 1'b1;
      tick();
      if (done1 !== 1'b0 || busy1 !== 1'b1 || ferr1 !== 1'b1) bad_done++;
    end
    req1 = 1'b0;
    n_checks++;
    if (bad_done != 0) begin n_errors++; $display("FAIL mis1_terminal: got %0d bad cycles want 0", bad_done); end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    n_checks += 2;
    if (ferr1 !== 1'b0) begin n_errors++; $display("FAIL mis1_reset_fsm_err: got %b want 0", ferr1); end
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL mis1_reset_busy: got %b want 0", busy1); end
  endtask

  task automatic test_fault_state();
    force dut1.state_q = 6'b100001;
    tick();
    release dut1.state_q;
    tick();
    tick();
    n_checks += 4;
    if (ferr1 !== 1'b1) begin n_errors++; $display("FAIL state_fsm_err: got %b want 1", ferr1); end
    if (code1 !== 2'd3) begin n_errors++; $display("FAIL state_code: got %0d want 3", code1); end
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL state_busy: got %b want 1", busy1); end
    if (done1 !== 1'b0) begin n_errors++; $display("FAIL state_done: got %b want 0", done1); end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    n_checks++;
    if (ferr1 !== 1'b0 || busy1 !== 1'b0) begin
      n_errors++;
      $display("FAIL state_reset: got ferr=%b busy=%b want 0 0", ferr1, busy1);
    end
  endtask

  task automatic test_small_params();
    int lat, elat; logic [3:0] res, eres; logic [1:0] code, ecode;
    int cur, tgt;
    logic [63:0] t;
    n_checks++;
    if (busy2 !== 1'b0 || res2 !== OFF || code2 !== 2'd0 || ferr2 !== 1'b0) begin
      n_errors++;
      $display("FAIL small_reset: got busy=%b res=%b code=%0d ferr=%b", busy2, res2, code2, ferr2);
    end
    // Mid-check reset on the small instance, then a normal transaction.
    cur2 = 3'd0; tgt2 = 3'd1; tok_in2 = tok2[mat2[0][1]]; req2 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      req2 = 1'b0;
    end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    n_checks++;
    if (busy2 !== 1'b0 || res2 !== OFF || code2 !== 2'd0 || done2 !== 1'b0) begin
      n_errors++;
      $display("FAIL small_rstmid: got busy=%b res=%b code=%0d done=%b", busy2, res2, code2, done2);
    end
    run2(0, 1, tok2[mat2[0][1]], lat, res, code);
    n_checks++;
    if (lat != 10 || res !== ON || code !== 2'd0) begin
      n_errors++;
      $display("FAIL small_pass: got lat=%0d res=%b code=%0d want lat=10 res=%b code=0", lat, res, code, ON);
    end
    for (int n = 0; n < 20; n++) begin
      cur = $urandom_range(0, 7);
      tgt = $urandom_range(0, 7);
      t   = tok2[mat2[cur][tgt]];
      if ($urandom_range(0, 1) == 1) t[$urandom_range(0, 63)] ^= 1'b1;
      model2(cur, tgt, t, elat, eres, ecode);
      run2(cur, tgt, t, lat, res, code);
      n_checks++;
      if (lat != elat || res !== eres || code !== ecode) begin
        n_errors++;
        $display("FAIL small_random[%0d] cur=%0d tgt=%0d: got lat=%0d res=%b code=%0d want lat=%0d res=%b code=%0d",
                 n, cur, tgt, lat, res, code, elat, eres, ecode);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) tok1[k] = rand128();
    for (int k = 0; k < 4; k++) tok2[k] = {$urandom(), $urandom()};
    for (int i = 0; i < 21; i++)
      for (int j = 0; j < 21; j++) mat1[i][j] = 3'($urandom_range(0, 7));
    mat1[0][1]  = 3'd1;
    mat1[20][0] = 3'd7;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mat2[i][j] = 2'($urandom_range(0, 3));
    mat2[0][1] = 2'd2;
    for (int i = 0; i < 21; i++)
      for (int j = 0; j < 21; j++) tm1[(i*21+j)*3 +: 3] = mat1[i][j];
    for (int k = 0; k < 8; k++) ht1[k*128 +: 128] = tok1[k];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) tm2[(i*8+j)*2 +: 2] = mat2[i][j];
    for (int k = 0; k < 4; k++) ht2[k*64 +: 64] = tok2[k];

    req1 = 1'b0; cur1 = '0; tgt1 = '0; tok_in1 = '0;
    req2 = 1'b0; cur2 = '0; tgt2 = '0; tok_in2 = '0;
    rst1 = 1'b1; rst2 = 1'b1;
    tick(); tick(); tick();
    rst1 = 1'b0; rst2 = 1'b0;
    tick();

    test_reset();
    test_pass_and_mismatch();
    test_invalid_edge();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_fault_mis1();
    test_fault_state();
    test_small_params();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
